telemetry_framer: RTL and testbench

Periodic telemetry packetiser downstream of the velocity control loop. It snapshots measured velocity, setpoint, PID output and the integrator-overflow flag at a fixed sample rate. It serialises each snapshot into an 11-byte frame with header, sequence number and checksum. The frame is pushed byte-by-byte into the UART transmit FIFO write port under full-flag back-pressure, replacing the raw 32-bit velocity write path.

---
 rtl/telemetry_framer.sv | 215 +++++++++++++++++++++
 tb/tb_telemetry_framer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_framer.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_framer
// Description : Periodic telemetry packetiser. Every SAMPLE_DIV cycles it
//               snapshots velocity, setpoint, PID output and the integrator
//               overflow flag. It then streams an 11-byte frame into a UART
//               TX FIFO write port, honouring the FIFO full flag:
//                 A5 5A seq velH velL spH spL unH unL flags chk
//               flags = {6'b0, dropped, overflow}
//               chk   = XOR of bytes 2..9
// Ports       : clk          system clock
//               n_reset      asynchronous active-low reset
//               i_velocity   measured velocity (16b)
//               i_setpoint   velocity setpoint (16b)
//               i_un         PID controller output (16b)
//               i_overflow   PID integrator overflow flag
//               i_enable     telemetry enable (level)
//               i_full       UART TX FIFO full
//               o_wr_uart    byte write strobe (never high while i_full=1)
//               o_data       byte being offered, held stable while stalled
//               o_busy       frame in progress
//               o_frame_done pulse on acceptance of the last byte
//               o_drop_count saturating count of ticks lost to a busy frame
// Revision    : 1.0 - initial release
// ============================================================================
module telemetry_framer #(
   parameter int SAMPLE_DIV = 65536
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [15:0] i_velocity,
   input  logic [15:0] i_setpoint,
   input  logic [15:0] i_un,
   input  logic        i_overflow,
   input  logic        i_enable,
   input  logic        i_full,
   output logic        o_wr_uart,
   output logic [7:0]  o_data,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic [7:0]  o_drop_count
);

   localparam int               CNT_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [3:0]       LAST_BYTE = 4'd10;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [CNT_W-1:0] tick_cnt;
   logic             tick;

   logic [3:0]       idx;
   logic [15:0]      snap_vel;
   logic [15:0]      snap_sp;
   logic [15:0]      snap_un;
   logic             snap_ovf;
   logic [7:0]       seq;
   logic [7:0]       chk;
   logic [7:0]       drop_count;
   logic             dropped;

   logic [7:0]       cur_byte;
   logic             start;
   logic             accept;
   logic             last_accept;
   logic             drop;

   // ------------------------------------------------------------------------
   // Free-running sample divider; keeps counting even when disabled so the
   // sample grid stays fixed relative to reset.
   // ------------------------------------------------------------------------
   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and control strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx    = state;
      start       = 1'b0;
      accept      = 1'b0;
      last_accept = 1'b0;
      drop        = 1'b0;
      case (state)
         IDLE: begin
            if (tick && i_enable) begin
               start    = 1'b1;
               state_nx = SEND;
            end
         end
         SEND: begin
            accept = !i_full;
            // A tick that lands while a frame is still in flight is lost,
            // including the cycle in which the last byte goes out.
            drop   = tick;
            if (!i_full && (idx == LAST_BYTE)) begin
               last_accept = 1'b1;
               state_nx    = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Byte selector. Built purely from registered state so o_data cannot
   // glitch with i_full. The flags byte reads the live sticky flag, so a drop
   // occurring before byte 9 is reported in the frame that suffered it.
   // ------------------------------------------------------------------------
   always_comb begin
      cur_byte = 8'h00;
      case (idx)
         4'd0:    cur_byte = 8'hA5;
         4'd1:    cur_byte = 8'h5A;
         4'd2:    cur_byte = seq;
         4'd3:    cur_byte = snap_vel[15:8];
         4'd4:    cur_byte = snap_vel[7:0];
         4'd5:    cur_byte = snap_sp[15:8];
         4'd6:    cur_byte = snap_sp[7:0];
         4'd7:    cur_byte = snap_un[15:8];
         4'd8:    cur_byte = snap_un[7:0];
         4'd9:    cur_byte = {6'b0, dropped, snap_ovf};
         4'd10:   cur_byte = chk;
         default: cur_byte = 8'h00;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: snapshot, byte index, running checksum, sequence, drop stats
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         idx        <= 4'd0;
         snap_vel   <= 16'h0000;
         snap_sp    <= 16'h0000;
         snap_un    <= 16'h0000;
         snap_ovf   <= 1'b0;
         seq        <= 8'h00;
         chk        <= 8'h00;
         drop_count <= 8'h00;
         dropped    <= 1'b0;
      end else begin
         if (start) begin
            snap_vel <= i_velocity;
            snap_sp  <= i_setpoint;
            snap_un  <= i_un;
            snap_ovf <= i_overflow;
            idx      <= 4'd0;
            chk      <= 8'h00;
         end else if (accept) begin
            if (idx != LAST_BYTE) begin
               idx <= idx + 4'd1;
            end
            // Checksum covers exactly the bytes as they were accepted.
            if ((idx >= 4'd2) && (idx <= 4'd9)) begin
               chk <= chk ^ cur_byte;
            end
         end

         if (last_accept) begin
            seq <= seq + 8'd1;
         end

         // A drop in the frame-end cycle wins over the end-of-frame clear.
         if (drop) begin
            dropped <= 1'b1;
            if (drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
         end else if (last_accept) begin
            dropped <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_wr_uart    = accept;
   assign o_data       = (state == SEND) ? cur_byte : 8'h00;
   assign o_busy       = (state == SEND);
   assign o_frame_done = last_accept;
   assign o_drop_count = drop_count;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_telemetry_framer
// Description : Self-checking bench for telemetry_framer. A frame-level
//               reference model predicts every output each cycle; scenario
//               tasks add directed checks on captured byte streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_framer;

   localparam int DIV = 16;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic [15:0] velocity = 16'h0000;
   logic [15:0] setpoint = 16'h0000;
   logic [15:0] un = 16'h0000;
   logic        overflow = 1'b0;
   logic        enable = 1'b0;
   logic        full = 1'b0;
   logic        o_wr_uart;
   logic [7:0]  o_data;
   logic        o_busy;
   logic        o_frame_done;
   logic [7:0]  o_drop_count;

   always #5 clk = ~clk;

   telemetry_framer #(.SAMPLE_DIV(DIV)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .i_velocity   (velocity),
      .i_setpoint   (setpoint),
      .i_un         (un),
      .i_overflow   (overflow),
      .i_enable     (enable),
      .i_full       (full),
      .o_wr_uart    (o_wr_uart),
      .o_data       (o_data),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_drop_count (o_drop_count)
   );

   int checks = 0;
   int passed = 0;

   // reference model state
   int unsigned ncyc;
   bit          m_send;
   int          m_idx;
   logic [7:0]  m_seq;
   logic [7:0]  m_drops;
   bit          m_dropped;
   logic [15:0] m_vel, m_sp, m_un;
   bit          m_ovf;
   logic [7:0]  m_flags_sent;

   logic [18:0] exp_vec;
   wire  [18:0] dut_vec = {o_wr_uart, o_data, o_busy, o_frame_done, o_drop_count};

   logic [7:0]  got[$];
   int          got_cyc[$];

   logic [7:0]  exp_basic [11] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h96, 8'h00,
                                   8'h96, 8'h12, 8'h34, 8'h00, 8'h26};

   // Frame content from the snapshot; the checksum uses the flags value that
   // actually went out once byte 9 has been sent.
   function automatic logic [7:0] frame_byte(input int k);
      logic [7:0] b [11];
      b[0] = 8'hA5;          b[1] = 8'h5A;         b[2] = m_seq;
      b[3] = m_vel[15:8];    b[4] = m_vel[7:0];
      b[5] = m_sp[15:8];     b[6] = m_sp[7:0];
      b[7] = m_un[15:8];     b[8] = m_un[7:0];
      b[9] = (k == 10) ? m_flags_sent : {6'b0, m_dropped, m_ovf};
      b[10] = 8'h00;
      for (int i = 2; i < 10; i++) b[10] = b[10] ^ b[i];
      return b[k];
   endfunction

   function automatic logic [7:0] xor_range(input int lo, input int hi);
      logic [7:0] x = 8'h00;
      for (int i = lo; i <= hi; i++) x = x ^ got[i];
      return x;
   endfunction

   task automatic model_clear();
      ncyc = 0; m_send = 0; m_idx = 0; m_seq = 8'h00; m_drops = 8'h00;
      m_dropped = 0; m_flags_sent = 8'h00;
      got.delete(); got_cyc.delete();
   endtask

   // Predict this cycle's outputs (sampled at negedge) and advance the model.
   task automatic eval_cycle();
      bit         tk, was, wr;
      logic [7:0] d;
      @(negedge clk);
      tk  = ((ncyc % DIV) == DIV - 1);
      was = m_send;
      d   = m_send ? frame_byte(m_idx) : 8'h00;
      wr  = m_send && !full;
      exp_vec = {wr, d, m_send, wr && (m_idx == 10), m_drops};
      if (o_wr_uart) begin
         got.push_back(o_data);
         got_cyc.push_back(int'(ncyc));
      end
      if (wr) begin
         if (m_idx == 9) m_flags_sent = d;
         if (m_idx == 10) begin
            m_send = 0; m_seq = m_seq + 8'd1; m_dropped = 0;
         end else begin
            m_idx++;
         end
      end
      if (tk) begin
         if (was) begin
            if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
            m_dropped = 1;
         end else if (enable) begin
            m_send = 1; m_idx = 0;
            m_vel = velocity; m_sp = setpoint; m_un = un; m_ovf = overflow;
         end
      end
      ncyc++;
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      model_clear();
      n_reset = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      n_reset = 1'b0;
      repeat (2) @(posedge clk);
      release_reset();
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      n_reset = 1'b0; enable = 1'b1; full = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (o_wr_uart !== 1'b0) $display("FAIL reset_wr got %b exp 0", o_wr_uart); else passed++;
      checks++; if (o_data !== 8'h00) $display("FAIL reset_data got %h exp 00", o_data); else passed++;
      checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", o_busy); else passed++;
      checks++; if (o_frame_done !== 1'b0) $display("FAIL reset_done got %b exp 0", o_frame_done); else passed++;
      checks++; if (o_drop_count !== 8'h00) $display("FAIL reset_drops got %h exp 00", o_drop_count); else passed++;
      release_reset();
   endtask

   task automatic test_basic_frame();
      velocity = 16'h0096; setpoint = 16'h0096; un = 16'h1234; overflow = 0;
      enable = 1; full = 0;
      do_reset();
      for (int c = 0; c < 48; c++) begin
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL basic_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
      end
      checks++; if (got.size() != 22) $display("FAIL basic_count got %0d exp 22", got.size()); else passed++;
      if (got.size() >= 22) begin
         checks++; if (got_cyc[0] != DIV) $display("FAIL basic_first_cycle got %0d exp %0d", got_cyc[0], DIV); else passed++;
         checks++; if (got_cyc[10] != DIV + 10) $display("FAIL basic_last_cycle got %0d exp %0d", got_cyc[10], DIV + 10); else passed++;
         for (int i = 0; i < 11; i++) begin
            checks++; if (got[i] !== exp_basic[i]) $display("FAIL basic_byte%0d got %h exp %h", i, got[i], exp_basic[i]); else passed++;
         end
         checks++; if (got[13] !== 8'h01) $display("FAIL basic_seq2 got %h exp 01", got[13]); else passed++;
      end
   endtask

   task automatic test_back_pressure();
      int stall = 0;
      int budget = 80;
      velocity = 16'h0096; setpoint = 16'h0096; un = 16'h1234; overflow = 0;
      enable = 1; full = 0;
      do_reset();
      while (got.size() < 11 && budget > 0) begin
         full = m_send && (m_idx == 3) && (stall < 5);
         if (full) stall++;
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL bp_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
         budget--;
      end
      full = 0;
      checks++; if (got.size() < 11) $display("FAIL bp_timeout got %0d bytes exp 11", got.size()); else passed++;
      if (got.size() >= 11) begin
         for (int i = 0; i < 11; i++) begin
            checks++; if (got[i] !== exp_basic[i]) $display("FAIL bp_byte%0d got %h exp %h", i, got[i], exp_basic[i]); else passed++;
         end
         checks++; if (got_cyc[3] - got_cyc[2] != 6) $display("FAIL bp_stall_gap got %0d exp 6", got_cyc[3] - got_cyc[2]); else passed++;
         checks++; if (got_cyc[10] - got_cyc[0] != 15) $display("FAIL bp_duration got %0d exp 15", got_cyc[10] - got_cyc[0]); else passed++;
      end
   endtask

   task automatic test_drop_overflow();
      int stall = 0;
      int budget = 150;
      velocity = 16'($urandom); setpoint = 16'($urandom); un = 16'($urandom);
      overflow = 1; enable = 1; full = 0;
      do_reset();
      while (got.size() < 33 && budget > 0) begin
         full = m_send && (m_idx == 4) && (stall < 20);
         if (full) stall++;
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL drop_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
         budget--;
      end
      full = 0;
      checks++; if (got.size() < 33) $display("FAIL drop_timeout got %0d bytes exp 33", got.size()); else passed++;
      checks++; if (o_drop_count !== 8'd1) $display("FAIL drop_count got %0d exp 1", o_drop_count); else passed++;
      if (got.size() >= 33) begin
         checks++; if (got[9] !== 8'h03) $display("FAIL drop_flags_a got %h exp 03", got[9]); else passed++;
         checks++; if (got[10] !== xor_range(2, 9)) $display("FAIL drop_chk_a got %h exp %h", got[10], xor_range(2, 9)); else passed++;
         checks++; if (got[20] !== 8'h01) $display("FAIL drop_flags_b got %h exp 01", got[20]); else passed++;
         checks++; if (got[21] !== xor_range(13, 20)) $display("FAIL drop_chk_b got %h exp %h", got[21], xor_range(13, 20)); else passed++;
         checks++; if (got[31] !== 8'h01) $display("FAIL drop_flags_c got %h exp 01", got[31]); else passed++;
      end
      overflow = 0;
   endtask

   task automatic test_snapshot();
      bit changed = 0;
      int budget = 80;
      velocity = 16'h1111; setpoint = 16'h2222; un = 16'h3333; enable = 1; full = 0;
      do_reset();
      while (got.size() < 22 && budget > 0) begin
         if (!changed && m_send && m_idx == 2) begin
            velocity = 16'h0FFF; changed = 1;
         end
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL snap_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
         budget--;
      end
      checks++; if (got.size() < 22) $display("FAIL snap_timeout got %0d bytes exp 22", got.size()); else passed++;
      if (got.size() >= 22) begin
         checks++; if ({got[3], got[4]} !== 16'h1111) $display("FAIL snap_vel_a got %h%h exp 1111", got[3], got[4]); else passed++;
         checks++; if ({got[14], got[15]} !== 16'h0FFF) $display("FAIL snap_vel_b got %h%h exp 0fff", got[14], got[15]); else passed++;
      end
   endtask

   task automatic test_enable_reset();
      int budget = 40;
      velocity = 16'hBEEF; setpoint = 16'h1357; un = 16'h2468; enable = 1; full = 0;
      do_reset();
      for (int c = 0; c < 80; c++) begin
         if (m_send && m_idx == 5) enable = 0;
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL en_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
      end
      checks++; if (got.size() != 11) $display("FAIL en_bytes got %0d exp 11", got.size()); else passed++;
      checks++; if (o_busy !== 1'b0) $display("FAIL en_idle_busy got %b exp 0", o_busy); else passed++;
      enable = 1;
      while (!(m_send && m_idx == 7) && budget > 0) begin
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL en2_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
         budget--;
      end
      checks++; if (budget == 0) $display("FAIL en2_timeout got no byte 7 exp byte 7"); else passed++;
      n_reset = 1'b0;
      #1;
      checks++; if (o_wr_uart !== 1'b0) $display("FAIL midrst_wr got %b exp 0", o_wr_uart); else passed++;
      checks++; if (o_data !== 8'h00) $display("FAIL midrst_data got %h exp 00", o_data); else passed++;
      checks++; if (o_busy !== 1'b0) $display("FAIL midrst_busy got %b exp 0", o_busy); else passed++;
      checks++; if (o_frame_done !== 1'b0) $display("FAIL midrst_done got %b exp 0", o_frame_done); else passed++;
      @(posedge clk); #1;
      release_reset();
      budget = 40;
      while (got.size() < 11 && budget > 0) begin
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL en3_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
         budget--;
      end
      checks++; if (got.size() < 11) $display("FAIL en3_timeout got %0d bytes exp 11", got.size()); else passed++;
      if (got.size() >= 11) begin
         checks++; if (got[2] !== 8'h00) $display("FAIL en3_seq got %h exp 00", got[2]); else passed++;
      end
   endtask

   task automatic test_saturation();
      int budget = 40;
      enable = 1; full = 1; overflow = 0;
      do_reset();
      for (int c = 0; c < 300 * DIV + 20; c++) begin
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL sat_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
      end
      checks++; if (o_drop_count !== 8'd255) $display("FAIL sat_drops got %0d exp 255", o_drop_count); else passed++;
      checks++; if (got.size() != 0) $display("FAIL sat_strobes got %0d exp 0", got.size()); else passed++;
      full = 0;
      while (got.size() < 11 && budget > 0) begin
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL sat2_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
         budget--;
      end
      checks++; if (got.size() < 11) $display("FAIL sat2_timeout got %0d bytes exp 11", got.size()); else passed++;
      if (got.size() >= 11) begin
         checks++; if (got[9] !== 8'h02) $display("FAIL sat_flags got %h exp 02", got[9]); else passed++;
      end
   endtask

   task automatic test_seq_wrap();
      enable = 1; full = 0;
      do_reset();
      for (int c = 0; c < 257 * DIV + 16; c++) begin
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL wrap_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
      end
      checks++; if (got.size() < 257 * 11) $display("FAIL wrap_count got %0d exp %0d", got.size(), 257 * 11); else passed++;
      if (got.size() >= 257 * 11) begin
         checks++; if (got[255 * 11 + 2] !== 8'hFF) $display("FAIL wrap_seq255 got %h exp ff", got[255 * 11 + 2]); else passed++;
         checks++; if (got[256 * 11 + 2] !== 8'h00) $display("FAIL wrap_seq256 got %h exp 00", got[256 * 11 + 2]); else passed++;
      end
   endtask

   task automatic test_random();
      enable = 1; full = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         full     = ($urandom_range(0, 99) < 30);
         enable   = ($urandom_range(0, 99) < 85);
         velocity = 16'($urandom);
         setpoint = 16'($urandom);
         un       = 16'($urandom);
         overflow = 1'($urandom);
         eval_cycle();
         checks++; if (dut_vec !== exp_vec) $display("FAIL rand_cycle t=%0t got %h exp %h", $time, dut_vec, exp_vec); else passed++;
         @(posedge clk); #1;
      end
      for (int f = 0; f + 10 < got.size(); f += 11) begin
         checks++; if (got[f + 10] !== xor_range(f + 2, f + 9)) $display("FAIL rand_chk frame %0d got %h exp %h", f / 11, got[f + 10], xor_range(f + 2, f + 9)); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_back_pressure();
      test_drop_overflow();
      test_snapshot();
      test_enable_reset();
      test_saturation();
      test_seq_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
